fp_mult_sched: RTL
==================

Name: fp_mult_sched

Overview:
- Shares one fixed-latency, non-stallable FP32 multiplier datapath (multiplier core followed by the exception stage) between two requesters.
- Round-robin arbitration with valid/ready handshakes on the request side.
- Tags every issued operation and steers each returning result and status flags to a per-requester response FIFO.
- Uses credit-based issue control so a result never arrives without FIFO space.
- Sits between the requesters and the multiplier top in the FP cluster.

Parameters:
- LATENCY, 3, multiplier issue-to-result latency in cycles (legal: >= 1).
- DEPTH, 4, entries per response FIFO (legal: >= 1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_a  in  32  requester 0 operand a (FP32).
- req0_b  in  32  requester 0 operand b (FP32).
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req1_valid / req1_a / req1_b / req1_ready  same as requester 0, for requester 1.
- mult_valid  out  1  issue strobe to multiplier.
- mult_a  out  32  operand a to multiplier.
- mult_b  out  32  operand b to multiplier.
- mult_z  in  32  multiplier result; valid LATENCY cycles after issue.
- mult_status  in  6  {zero_f, inf_f, nan_f, tiny_f, huge_f, inexact_f}, aligned with mult_z.
- rsp0_valid  out  1  requester 0 result available.
- rsp0_z  out  32  requester 0 result.
- rsp0_status  out  6  requester 0 status flags.
- rsp0_ready  in  1  requester 0 consumes the result.
- rsp1_valid / rsp1_z / rsp1_status / rsp1_ready  same as requester 0, for requester 1.

Behaviour:
- Clocking: one clock `clk`; `rst` is synchronous and active-high. All state updates on the rising edge of `clk`.
- Reset values:
  - mult_valid = 0; mult_a = mult_b = 0.
  - req*_ready = 0 during reset.
  - rsp*_valid = 0.
  - Credits = DEPTH each.
  - Tag pipeline cleared.
  - FIFO pointers and counts = 0.
  - last_grant = 1, so requester 0 wins the first tie.
- Credits:
  - Per requester, credit_i = free FIFO slots minus results in flight; width $clog2(DEPTH+1).
  - Decrement on an issue for i; increment on an rsp_i pop; simultaneous issue and pop leaves it unchanged.
  - Never below 0; never above DEPTH.
- Eligibility: elig_i = req_i_valid && credit_i != 0.
- Arbitration (combinational, same cycle):
  - One eligible requester: it is granted.
  - Both eligible: grant the requester != last_grant.
  - req_i_ready = grant_i. An issue occurs when req_i_valid && req_i_ready.
  - last_grant updates only on an issue.
  - A requester holding valid while out of credit does not block the other requester.
- Issue:
  - mult_valid = any grant; mult_a/mult_b = granted requester's operands.
  - Outputs are combinational from the request ports; mult_a/mult_b = 0 when no grant.
  - Throughput: one issue per cycle.
- Tag pipeline:
  - LATENCY-stage shift register of {valid, id}; stage 0 is loaded on issue at cycle t.
  - At cycle t+LATENCY the tag exits, and mult_z/mult_status are written into FIFO[id] at the end of that cycle.
  - Untagged cycles ignore mult_z.
- Response FIFO:
  - First-word-fall-through: rsp_i_valid = !empty.
  - Pop when valid && ready.
  - Push and pop in the same cycle are both honoured.
  - Push into a full FIFO is impossible by credit construction. Verification asserts it; RTL has no overflow path.
  - Pointers wrap modulo DEPTH.
- Latency: issue at t → rsp_valid high at t+LATENCY+1 at the earliest (empty FIFO).
- Ordering: results are delivered in issue order per requester. There is no ordering guarantee across requesters.
- Reset mid-operation:
  - In-flight tags are discarded, so their later mult_z values are dropped.
  - FIFO contents are lost and credits are restored to DEPTH.
- Data: results and flags pass through unmodified. The scheduler performs no arithmetic on operands.

Decomposition:
- Package fp_mult_pkg holds:
  - STATUS_W = 6 and the bit-index constants for the six flags.
  - The rounding-mode enum shared with the exception stage.
  - A packed struct fp_rsp_t {z[31:0], status[5:0]}.
- Sub-module fp_rsp_fifo:
  - Parameterised by DEPTH; stores fp_rsp_t; first-word-fall-through.
  - Outputs count and empty.
  - Instantiated twice.
- Arbitration, credits and the tag pipeline stay in the top module.

Test Plan:
- Single op: LATENCY=3; req0 issues a=0x40000000, b=0x40400000 at cycle 5 with mult_z model 0x40C00000, status 0 → rsp0_valid at cycle 9 with z=0x40C00000; rsp1_valid stays 0.
- Contention: both valid continuously after reset → grants alternate 0,1,0,1…; first grant goes to 0; one mult_valid per cycle; each requester gets results in its own issue order.
- Backpressure: rsp0_ready=0 and req0 streams → exactly DEPTH=4 issues for requester 0, then req0_ready=0 while req1 keeps issuing every cycle. Raising rsp0_ready for 1 cycle → exactly one further req0 issue.
- Simultaneous issue and pop: credit_0=1, and in the same cycle an issue for 0 and an rsp0 pop occur → credit_0 stays 1 and the FIFO count is consistent. Assertion: no FIFO overflow ever.
- Flag passthrough: mult_status=6'b100000 (zero) for a req1 op, then 6'b001000 (nan) → rsp1_status delivers those values in order, unmodified.
- Reset mid-flight: 2 ops in the tag pipeline and 1 in FIFO0, assert rst for 1 cycle → all rsp_valid=0; later mult_z values are not captured; credits=4; the next tie grants requester 0.

Source files
------------

// File: rtl/fp_mult_pkg.sv
// Shared types and constants for the FP32 multiplier cluster: status flag
// layout, rounding modes and the response word stored by the scheduler FIFOs.
package fp_mult_pkg;

    // Status vector is {zero, inf, nan, tiny, huge, inexact}, MSB first.
    localparam int STATUS_W   = 6;
    localparam int ST_ZERO    = 5;
    localparam int ST_INF     = 4;
    localparam int ST_NAN     = 3;
    localparam int ST_TINY    = 2;
    localparam int ST_HUGE    = 1;
    localparam int ST_INEXACT = 0;

    // Rounding modes understood by the exception stage.
    typedef enum logic [2:0] {
        RND_NE = 3'd0,   // round to nearest, ties to even
        RND_TZ = 3'd1,   // toward zero
        RND_DN = 3'd2,   // toward -inf
        RND_UP = 3'd3,   // toward +inf
        RND_MM = 3'd4    // nearest, ties away from zero
    } rnd_mode_e;

    // One multiplier response: result word plus its flags.
    typedef struct packed {
        logic [31:0]         z;
        logic [STATUS_W-1:0] status;
    } fp_rsp_t;

    localparam int RSP_W = $bits(fp_rsp_t);

    // Pointer width for a DEPTH-entry ring; at least one bit so DEPTH=1 works.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fp_rsp_fifo.sv
// First-word-fall-through response FIFO holding fp_rsp_t entries.
// The producer guarantees it never pushes while full, so there is no
// overflow protection here; pop is only issued while non-empty.
module fp_rsp_fifo
    import fp_mult_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [RSP_W-1:0] push_data_i,
    input  logic             pop_i,
    output logic [RSP_W-1:0] pop_data_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int               PTR_W    = ptr_width(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    fp_rsp_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Pointers wrap at DEPTH-1; count tracks push/pop, both may happen together.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push_i && !pop_i) begin
                count_q <= count_q + 1'b1;
            end else if (!push_i && pop_i) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage has no reset; validity is carried entirely by the count.
    always_ff @(posedge clk) begin
        if (push_i && !rst) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/fp_mult_sched.sv
// Two-requester scheduler in front of a fixed-latency FP32 multiplier.
// Round-robin grant, credit-gated issue, a tag pipeline that follows each
// operation through the multiplier, and one response FIFO per requester.
// A requester's credit counts its free FIFO slots minus its results in
// flight, so a returning result always has a slot waiting for it.
module fp_mult_sched
    import fp_mult_pkg::*;
#(
    parameter int LATENCY = 3,
    parameter int DEPTH   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    input  logic [31:0]         req0_a,
    input  logic [31:0]         req0_b,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [31:0]         req1_a,
    input  logic [31:0]         req1_b,
    output logic                req1_ready,
    output logic                mult_valid,
    output logic [31:0]         mult_a,
    output logic [31:0]         mult_b,
    input  logic [31:0]         mult_z,
    input  logic [STATUS_W-1:0] mult_status,
    output logic                rsp0_valid,
    output logic [31:0]         rsp0_z,
    output logic [STATUS_W-1:0] rsp0_status,
    input  logic                rsp0_ready,
    output logic                rsp1_valid,
    output logic [31:0]         rsp1_z,
    output logic [STATUS_W-1:0] rsp1_status,
    input  logic                rsp1_ready
);

    // Handshake: an operation transfers on a cycle where reqN_valid and
    // reqN_ready are both high; a response transfers where rspN_valid and
    // rspN_ready are both high. Valid never depends on ready.

    localparam int                CRED_W   = $clog2(DEPTH + 1);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(DEPTH);

    logic [CRED_W-1:0]  credit0_q, credit0_d;
    logic [CRED_W-1:0]  credit1_q, credit1_d;
    logic               last_grant_q, last_grant_d;
    logic [LATENCY-1:0] tag_vld_q;
    logic [LATENCY-1:0] tag_id_q;

    logic               elig0, elig1;
    logic               grant0, grant1;
    logic               issue;
    logic               push0, push1;
    logic               pop0, pop1;
    logic               empty0, empty1;
    logic [CRED_W-1:0]  count0, count1;
    logic [RSP_W-1:0]   rsp_in;
    logic [RSP_W-1:0]   rsp0_data, rsp1_data;
    fp_rsp_t            rsp0_word, rsp1_word;

    // Round-robin arbitration among requesters that are valid and hold credit.
    always_comb begin
        elig0  = !rst && req0_valid && (credit0_q != '0);
        elig1  = !rst && req1_valid && (credit1_q != '0);
        grant0 = elig0 && (!elig1 || last_grant_q);
        grant1 = elig1 && (!elig0 || !last_grant_q);
        issue  = grant0 || grant1;
        last_grant_d = last_grant_q;
        if (issue) begin
            last_grant_d = grant1;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign mult_valid = issue;

    // Operand mux toward the multiplier; zero when nothing is granted.
    always_comb begin
        mult_a = '0;
        mult_b = '0;
        if (grant0) begin
            mult_a = req0_a;
            mult_b = req0_b;
        end else if (grant1) begin
            mult_a = req1_a;
            mult_b = req1_b;
        end
    end

    // The tag leaving the last stage marks mult_z/mult_status as valid now.
    assign push0 = tag_vld_q[LATENCY-1] && !tag_id_q[LATENCY-1];
    assign push1 = tag_vld_q[LATENCY-1] &&  tag_id_q[LATENCY-1];
    assign pop0  = rsp0_ready && (count0 != '0);
    assign pop1  = rsp1_ready && (count1 != '0);

    // Credit bookkeeping: issue consumes a slot, pop returns one.
    always_comb begin
        credit0_d = credit0_q;
        credit1_d = credit1_q;
        if (grant0 && !pop0) begin
            credit0_d = credit0_q - 1'b1;
        end else if (pop0 && !grant0) begin
            credit0_d = credit0_q + 1'b1;
        end
        if (grant1 && !pop1) begin
            credit1_d = credit1_q - 1'b1;
        end else if (pop1 && !grant1) begin
            credit1_d = credit1_q + 1'b1;
        end
    end

    // Credits, grant history and the tag shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit0_q    <= CRED_MAX;
            credit1_q    <= CRED_MAX;
            last_grant_q <= 1'b1;
            tag_vld_q    <= '0;
            tag_id_q     <= '0;
        end else begin
            credit0_q    <= credit0_d;
            credit1_q    <= credit1_d;
            last_grant_q <= last_grant_d;
            tag_vld_q[0] <= issue;
            tag_id_q[0]  <= grant1;
            for (int k = 1; k < LATENCY; k++) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_id_q[k]  <= tag_id_q[k-1];
            end
        end
    end

    assign rsp_in = {mult_z, mult_status};

    fp_rsp_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push0),
        .push_data_i (rsp_in),
        .pop_i       (pop0),
        .pop_data_o  (rsp0_data),
        .empty_o     (empty0),
        .count_o     (count0)
    );

    fp_rsp_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push1),
        .push_data_i (rsp_in),
        .pop_i       (pop1),
        .pop_data_o  (rsp1_data),
        .empty_o     (empty1),
        .count_o     (count1)
    );

    assign rsp0_word   = rsp0_data;
    assign rsp1_word   = rsp1_data;
    assign rsp0_valid  = !empty0;
    assign rsp1_valid  = !empty1;
    assign rsp0_z      = rsp0_word.z;
    assign rsp0_status = rsp0_word.status;
    assign rsp1_z      = rsp1_word.z;
    assign rsp1_status = rsp1_word.status;

endmodule
